outagu_nd: RTL and testbench
============================

# outagu_nd

Parametrised N-dimensional output address generation unit for the MVU quantizer write-back path. It walks up to NLOOPS nested loops, each with its own trip count and signed address jump, and emits one local-data-memory write address per accepted `step`. Busy/done status lets the controller sequence multiple output tiles back-to-back.

## Interface
- `BDBANKA`, 15: address width; all address arithmetic is modulo 2^BDBANKA.
- `NLOOPS`, 3: number of nested loops, ≥1; loop 0 is innermost.
- `BLEN`, 16: trip-count width per loop.

- `clk` in 1: single clock, all logic on posedge.
- `clr` in 1: reset, synchronous, active-high; priority over everything.
- `load` in 1: latch configuration and start a new walk.
- `baseaddr` in BDBANKA: first address of the walk.
- `lengths` in NLOOPS*BLEN: packed trip counts, loop i at bits [i*BLEN +: BLEN].
- `jumps` in NLOOPS*BDBANKA: packed two's-complement jumps, loop i at [i*BDBANKA +: BDBANKA].
- `step` in 1: current address consumed; advance.
- `addrout` out BDBANKA: current write address (registered).
- `busy` out 1: walk in progress, `addrout` valid.
- `done` out 1: one-cycle pulse after final address consumed.
- `loopwrap` out NLOOPS: one-cycle pulse per loop that rolled over on the last step.

## Operation
- States: IDLE (busy=0) and RUN (busy=1). No other states.
- `load` (any state): latch `lengths`/`jumps` into internal registers, `addrout`←`baseaddr`, all counters←0, go RUN. Length 0 is treated as 1.
- RUN with `step`: let k = lowest loop whose counter ≠ length−1.
  - k exists: counters 0..k−1←0, counter k+1, `addrout`←`addrout`+jump[k]; `loopwrap`[j]=1 for j<k.
  - no k (all counters at length−1): final address consumed; go IDLE, `done`=1, `loopwrap` all ones, `addrout` holds.
- Jump semantics are relative: jump[k] is applied once loop k increments and lower loops reset; it already compensates for lower-loop travel.
- Total addresses per walk = product of (effective) lengths; exactly that many steps return to IDLE.
- `step` in IDLE: ignored, no outputs change.
- `load` and `step` in same cycle: `load` wins, step is dropped.
- Inputs `lengths`/`jumps` may change during RUN without effect; only the latched copies are used.
- Address overflow/underflow wraps modulo 2^BDBANKA, no flag.

## Timing
- Reset values: `addrout`=0, `busy`=0, `done`=0, `loopwrap`=0, all counters and latched configuration 0.
- `load` at edge n → `addrout`=`baseaddr`, `busy`=1 visible after edge n.
- `step` at edge n → new `addrout` visible after edge n (one-cycle latency); a step every cycle is sustained.
- `done`, `loopwrap` high exactly one cycle after the triggering edge, then 0.
- `busy` falls in the same cycle `done` rises.
- `clr` mid-walk: everything returns to reset values next edge; no `done`.

## Structure
- Shared package/header `outagu_pkg`: default BDBANKA/NLOOPS/BLEN and the IDLE/RUN state encodings.
- One sub-module `outagu_loopcnt`: single loop counter (count, length compare, at-max flag, clear/inc), instantiated NLOOPS times; top level holds priority encoder for k, jump mux, address adder and FSM.

## Test plan
- Reset: assert `clr` 2 cycles → `addrout`=0, `busy`=0, `done`=0, `loopwrap`=0.
- 1-D: base=100, lengths={1,1,4}, jump0=1, 4 steps → addresses 100,101,102,103; `done` after 4th step; `addrout` holds 103.
- 2-D with negative jump: base=0, len0=3, len1=2, jump0=2, jump1=−3 (wrapped) → 0,2,4,1,3,5; `loopwrap`[0] pulses on 3rd step; `done`+`loopwrap`=111 after 6th.
- Wrap-around: base=2^15−2, len0=4, jump0=1 → 32766,32767,0,1.
- Collisions: `load` with `step` mid-walk → restarts at new base, step ignored; `step` in IDLE → no change; length 0 behaves as 1.
- `clr` during RUN after 2 of 6 steps → `busy`=0, `addrout`=0, no `done` pulse.

Source files
------------

// File: rtl/outagu_pkg.sv
// outagu_pkg: shared defaults and FSM state encoding for the N-dimensional
// output address generation unit.
package outagu_pkg;

  localparam int unsigned BDBANKA_DEF = 15;
  localparam int unsigned NLOOPS_DEF  = 3;
  localparam int unsigned BLEN_DEF    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } outagu_state_e;

endpackage

// File: rtl/outagu_loopcnt.sv
// outagu_loopcnt: one loop counter of the address walk.
//   clk, clr    : clock, synchronous active-high reset
//   load        : latch length, restart count at 0
//   length      : trip count (0 treated as 1)
//   cnt_clr     : reset count to 0 (lower loop rolled over)
//   cnt_inc     : increment count
//   at_max      : count equals effective length-1
module outagu_loopcnt
  import outagu_pkg::*;
#(
  parameter int unsigned BLEN = BLEN_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic [BLEN-1:0] length,
  input  logic            cnt_clr,
  input  logic            cnt_inc,
  output logic            at_max
);

  logic [BLEN-1:0] count_q, count_d;
  logic [BLEN-1:0] max_q, max_d;

  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    if (load) begin
      count_d = '0;
      // Latch the terminal value instead of the raw length; zero maps to a single trip.
      max_d   = (length == '0) ? '0 : length - BLEN'(1);
    end else if (cnt_clr) begin
      count_d = '0;
    end else if (cnt_inc) begin
      count_d = count_q + BLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      max_q   <= '0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
    end
  end

  assign at_max = (count_q == max_q);

endmodule

// File: rtl/outagu_nd.sv
// outagu_nd: N-dimensional output address generator for the quantizer
// write-back path. Emits one address per accepted step over NLOOPS nested
// loops (loop 0 innermost), each with its own trip count and signed jump.
//   clk, clr  : clock, synchronous active-high reset
//   load      : latch lengths/jumps, addrout<=baseaddr, start walk
//   baseaddr  : first address
//   lengths   : packed trip counts, loop i at [i*BLEN +: BLEN]
//   jumps     : packed signed jumps, loop i at [i*BDBANKA +: BDBANKA]
//   step      : current address consumed, advance
//   addrout   : current address (registered)
//   busy      : walk in progress
//   done      : one-cycle pulse after final address consumed
//   loopwrap  : one-cycle pulse per loop that rolled over
module outagu_nd
  import outagu_pkg::*;
#(
  parameter int unsigned BDBANKA = BDBANKA_DEF,
  parameter int unsigned NLOOPS  = NLOOPS_DEF,
  parameter int unsigned BLEN    = BLEN_DEF
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      load,
  input  logic [BDBANKA-1:0]        baseaddr,
  input  logic [NLOOPS*BLEN-1:0]    lengths,
  input  logic [NLOOPS*BDBANKA-1:0] jumps,
  input  logic                      step,
  output logic [BDBANKA-1:0]        addrout,
  output logic                      busy,
  output logic                      done,
  output logic [NLOOPS-1:0]         loopwrap
);

  outagu_state_e               state_q, state_d;
  logic [BDBANKA-1:0]          addr_q, addr_d;
  logic [NLOOPS*BDBANKA-1:0]   jumps_q, jumps_d;
  logic                        done_q, done_d;
  logic [NLOOPS-1:0]           wrap_q, wrap_d;

  logic [NLOOPS-1:0]           at_max;
  logic [NLOOPS-1:0]           cnt_clr;
  logic [NLOOPS-1:0]           cnt_inc;

  for (genvar g = 0; g < NLOOPS; g++) begin : g_loop
    outagu_loopcnt #(.BLEN(BLEN)) u_cnt (
      .clk     (clk),
      .clr     (clr),
      .load    (load),
      .length  (lengths[g*BLEN +: BLEN]),
      .cnt_clr (cnt_clr[g]),
      .cnt_inc (cnt_inc[g]),
      .at_max  (at_max[g])
    );
  end

  logic               found;
  logic [BDBANKA-1:0] jump_sel;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    jumps_d  = jumps_q;
    done_d   = 1'b0;
    wrap_d   = '0;
    cnt_clr  = '0;
    cnt_inc  = '0;
    found    = 1'b0;
    jump_sel = '0;

    if (load) begin
      jumps_d = jumps;
      addr_d  = baseaddr;
      state_d = RUN;
    end else if (state_q == RUN && step) begin
      // Priority encoder fused with counter control: loops below the first
      // non-saturated loop roll over, that loop increments and selects the jump.
      for (int unsigned i = 0; i < NLOOPS; i++) begin
        if (!found) begin
          if (at_max[i]) begin
            cnt_clr[i] = 1'b1;
            wrap_d[i]  = 1'b1;
          end else begin
            found      = 1'b1;
            cnt_inc[i] = 1'b1;
            jump_sel   = jumps_q[i*BDBANKA +: BDBANKA];
          end
        end
      end
      if (found) begin
        addr_d = addr_q + jump_sel;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        wrap_d  = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      jumps_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      jumps_q <= jumps_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addrout  = addr_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign loopwrap = wrap_q;

endmodule

// File: tb/tb_outagu_nd.sv
// tb_outagu_nd: directed scoreboard bench for outagu_nd with default parameters.
module tb_outagu_nd;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic        step = 1'b0;
  logic [14:0] baseaddr = '0;
  logic [47:0] lengths = '0;
  logic [44:0] jumps = '0;
  logic [14:0] addrout;
  logic        busy;
  logic        done;
  logic [2:0]  loopwrap;

  always #5 clk = ~clk;

  outagu_nd #(.BDBANKA(15), .NLOOPS(3), .BLEN(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .baseaddr (baseaddr),
    .lengths  (lengths),
    .jumps    (jumps),
    .step     (step),
    .addrout  (addrout),
    .busy     (busy),
    .done     (done),
    .loopwrap (loopwrap)
  );

  typedef struct {
    int          id;
    logic [14:0] addr;
    logic        busy;
    logic        done;
    logic [2:0]  wrap;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   vec_id = 0;

  // Monitor: one expected record per driven cycle, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (addrout === e.addr) n_pass++;
      else $display("FAIL v%0d addrout: got %0d expected %0d", e.id, addrout, e.addr);
      n_chk++;
      if (busy === e.busy) n_pass++;
      else $display("FAIL v%0d busy: got %b expected %b", e.id, busy, e.busy);
      n_chk++;
      if (done === e.done) n_pass++;
      else $display("FAIL v%0d done: got %b expected %b", e.id, done, e.done);
      n_chk++;
      if (loopwrap === e.wrap) n_pass++;
      else $display("FAIL v%0d loopwrap: got %b expected %b", e.id, loopwrap, e.wrap);
    end
  end

  task automatic drive(input logic c, input logic l, input logic s,
                       input logic [14:0] b, input logic [47:0] len, input logic [44:0] jmp,
                       input logic [14:0] ea, input logic eb, input logic ed, input logic [2:0] ew);
    exp_t e;
    @(negedge clk);
    clr = c; load = l; step = s; baseaddr = b; lengths = len; jumps = jmp;
    e.id = vec_id; e.addr = ea; e.busy = eb; e.done = ed; e.wrap = ew;
    sb.push_back(e);
    vec_id++;
  endtask

  function automatic logic [47:0] lens(input int l2, input int l1, input int l0);
    return {16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [44:0] jmps(input int j2, input int j1, input int j0);
    return {15'(j2), 15'(j1), 15'(j0)};
  endfunction

  localparam logic [47:0] JUNK_L = 48'hFFFF_0000_7777;
  localparam logic [44:0] JUNK_J = 45'h1ABC_DEF0_1234;

  initial begin
    // Reset
    drive(1, 0, 0, 15'd0, '0, '0, 15'd0, 0, 0, 3'b000);
    drive(1, 0, 0, 15'd0, '0, '0, 15'd0, 0, 0, 3'b000);

    // 1-D walk: 100..103
    drive(0, 1, 0, 15'd100, lens(1, 1, 4), jmps(0, 0, 1), 15'd100, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd101, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd102, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd103, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd103, 0, 1, 3'b111);
    drive(0, 0, 0, 15'd0, JUNK_L, JUNK_J, 15'd103, 0, 0, 3'b000);
    // step in IDLE is ignored
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd103, 0, 0, 3'b000);

    // 2-D with negative jump (-3 -> 32765), config inputs scrambled during RUN
    drive(0, 1, 0, 15'd0, lens(1, 2, 3), jmps(0, 32765, 2), 15'd0, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd2, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd4, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd1, 1, 0, 3'b001);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd3, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd5, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd9, JUNK_L, JUNK_J, 15'd5, 0, 1, 3'b111);

    // Address wrap-around; outer lengths 0 act as 1
    drive(0, 1, 0, 15'd32766, lens(0, 0, 4), jmps(0, 0, 1), 15'd32766, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd32767, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd0, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd1, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd1, 0, 1, 3'b111);

    // load + step collision mid-walk: restart, step dropped
    drive(0, 1, 0, 15'd10, lens(1, 1, 5), jmps(0, 0, 1), 15'd10, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd11, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd12, 1, 0, 3'b000);
    drive(0, 1, 1, 15'd200, lens(1, 1, 2), jmps(0, 0, 7), 15'd200, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd207, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd207, 0, 1, 3'b111);

    // All lengths 0: a single-address walk
    drive(0, 1, 0, 15'd7, lens(0, 0, 0), jmps(5, 5, 5), 15'd7, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd7, 0, 1, 3'b111);

    // clr after 2 of 6 steps: back to reset values, no done
    drive(0, 1, 0, 15'd0, lens(1, 2, 3), jmps(0, 32765, 2), 15'd0, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd2, 1, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd4, 1, 0, 3'b000);
    drive(1, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd0, 0, 0, 3'b000);
    drive(0, 0, 1, 15'd0, JUNK_L, JUNK_J, 15'd0, 0, 0, 3'b000);
    drive(0, 0, 0, 15'd0, JUNK_L, JUNK_J, 15'd0, 0, 0, 3'b000);

    @(negedge clk);
    clr = 0; load = 0; step = 0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
